// File: rtl/ret_stack.sv
// Return-address stack: push/pop/flush with configurable depth, sticky
// overflow/underflow flags and a selectable full-stack policy
// (WRAP=0 saturate, WRAP=1 overwrite oldest). The top of stack is read
// combinationally from state only, so it is valid in the same cycle as pop.
module ret_stack #(
  parameter int WIDTH = 10,
  parameter int PTR_W = 3,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 2 ** PTR_W;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] tp_r;
  logic [PTR_W:0]   count_r;
  logic             overflow_r;
  logic             underflow_r;

  logic [PTR_W-1:0] tp_nxt_s;
  logic [PTR_W:0]   count_nxt_s;
  logic             we_s;
  logic [PTR_W-1:0] waddr_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic             empty_s;
  logic             full_s;
  logic [PTR_W-1:0] tp_dec_s;
  logic [PTR_W-1:0] tp_inc_s;

  assign empty_s  = (count_r == (PTR_W+1)'(0));
  assign full_s   = (count_r == (PTR_W+1)'(DEPTH));
  assign tp_dec_s = tp_r - PTR_W'(1);
  assign tp_inc_s = tp_r + PTR_W'(1);

  assign empty     = empty_s;
  assign full      = full_s;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign top       = empty_s ? {WIDTH{1'b0}} : mem_r[tp_dec_s];

  // Next-state decode for pointer, count, write port and error events.
  always_comb begin
    tp_nxt_s    = tp_r;
    count_nxt_s = count_r;
    we_s        = 1'b0;
    waddr_s     = tp_r;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    if (flush) begin
      tp_nxt_s    = {PTR_W{1'b0}};
      count_nxt_s = {(PTR_W+1){1'b0}};
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!full_s) begin
            we_s        = 1'b1;
            tp_nxt_s    = tp_inc_s;
            count_nxt_s = count_r + (PTR_W+1)'(1);
          end else begin
            ovf_set_s = 1'b1;
            if (WRAP != 0) begin
              we_s     = 1'b1;
              tp_nxt_s = tp_inc_s;
            end else begin
              we_s = 1'b0;
            end
          end
        end
        2'b01: begin
          if (!empty_s) begin
            tp_nxt_s    = tp_dec_s;
            count_nxt_s = count_r - (PTR_W+1)'(1);
          end else begin
            unf_set_s = 1'b1;
          end
        end
        2'b11: begin
          we_s = 1'b1;
          if (!empty_s) begin
            waddr_s = tp_dec_s;
          end else begin
            tp_nxt_s    = tp_inc_s;
            count_nxt_s = (PTR_W+1)'(1);
            unf_set_s   = 1'b1;
          end
        end
        default: begin
          we_s = 1'b0;
        end
      endcase
    end
  end

  // Pointer, count and sticky error flags; a newly raised error beats err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp_r        <= {PTR_W{1'b0}};
      count_r     <= {(PTR_W+1){1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      tp_r    <= tp_nxt_s;
      count_r <= count_nxt_s;
      if (ovf_set_s) overflow_r <= 1'b1;
      else if (err_clr) overflow_r <= 1'b0;
      else overflow_r <= overflow_r;
      if (unf_set_s) underflow_r <= 1'b1;
      else if (err_clr) underflow_r <= 1'b0;
      else underflow_r <= underflow_r;
    end
  end

  // Entry storage; contents are not reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (we_s && !reset) begin
      mem_r[waddr_s] <= push_data;
    end
  end

endmodule

// File: tb/tb_ret_stack.sv
// Bench for ret_stack: a saturating and a wrapping instance share stimulus;
// a list-based model of each stack is compared every cycle, plus literal
// expectations from hand-worked sequences.
`timescale 1ns/1ps
module tb_ret_stack;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [9:0] push_data = 10'd0;

  logic [9:0] top0, top1;
  logic [3:0] count0, count1;
  logic       empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model: entries[w][0] is the oldest, entries[w][cnt-1] the top
  logic [9:0] mm [2][8];
  int         cnt [2];
  bit         movf [2];
  bit         munf [2];

  always #5 clk = ~clk;

  ret_stack #(.WIDTH(10), .PTR_W(3), .WRAP(0)) d0 (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .err_clr(err_clr), .push_data(push_data), .top(top0), .count(count0),
    .empty(empty0), .full(full0), .overflow(ovf0), .underflow(unf0));

  ret_stack #(.WIDTH(10), .PTR_W(3), .WRAP(1)) d1 (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .err_clr(err_clr), .push_data(push_data), .top(top1), .count(count1),
    .empty(empty1), .full(full1), .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_top(input int w);
    return (cnt[w] == 0) ? 10'd0 : mm[w][cnt[w]-1];
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      cnt[w] = 0; movf[w] = 1'b0; munf[w] = 1'b0;
    end
  endtask

  task automatic model_step(input int w);
    bit os = 1'b0;
    bit us = 1'b0;
    if (flush) begin
      cnt[w] = 0;
    end else if (push && !pop) begin
      if (cnt[w] < 8) begin
        mm[w][cnt[w]] = push_data; cnt[w]++;
      end else begin
        os = 1'b1;
        if (w == 1) begin
          for (int i = 0; i < 7; i++) mm[w][i] = mm[w][i+1];
          mm[w][7] = push_data;
        end
      end
    end else if (pop && !push) begin
      if (cnt[w] > 0) cnt[w]--; else us = 1'b1;
    end else if (push && pop) begin
      if (cnt[w] > 0) mm[w][cnt[w]-1] = push_data;
      else begin mm[w][0] = push_data; cnt[w] = 1; us = 1'b1; end
    end
    if (os) movf[w] = 1'b1; else if (err_clr) movf[w] = 1'b0;
    if (us) munf[w] = 1'b1; else if (err_clr) munf[w] = 1'b0;
  endtask

  task automatic cyc(input logic pu, input logic po, input logic fl,
                     input logic ec, input logic [9:0] d);
    @(negedge clk);
    push = pu; pop = po; flush = fl; err_clr = ec; push_data = d;
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("top0", top0, exp_top(0));
      chk("count0", count0, cnt[0]);
      chk("empty0", empty0, cnt[0] == 0);
      chk("full0", full0, cnt[0] == 8);
      chk("ovf0", ovf0, movf[0]);
      chk("unf0", unf0, munf[0]);
      chk("top1", top1, exp_top(1));
      chk("count1", count1, cnt[1]);
      chk("empty1", empty1, cnt[1] == 0);
      chk("full1", full1, cnt[1] == 8);
      chk("ovf1", ovf1, movf[1]);
      chk("unf1", unf1, munf[1]);
    end
  end

  initial begin
    logic [9:0] exp_pops [3];
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_count", count0, 0);
    chk("rst_top", top0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // push 5, A, FF then pop x3
    cyc(1, 0, 0, 0, 10'h005);
    cyc(1, 0, 0, 0, 10'h00A);
    cyc(1, 0, 0, 0, 10'h0FF);
    chk("p3_count", count0, 3);
    chk("p3_top", top0, 10'h0FF);
    chk("p3_empty", empty0, 0);
    exp_pops[0] = 10'h0FF; exp_pops[1] = 10'h00A; exp_pops[2] = 10'h005;
    for (int i = 0; i < 3; i++) begin
      chk("pop_top", top0, exp_pops[i]);
      cyc(0, 1, 0, 0, 10'd0);
    end
    chk("p3_end_count", count0, 0);
    chk("p3_end_top", top0, 0);
    chk("p3_end_empty", empty0, 1);
    chk("p3_end_unf", unf0, 0);

    // saturate: push 1..8, then 9
    for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, 10'(i));
    chk("sat_full", full0, 1);
    chk("sat_count", count0, 8);
    cyc(1, 0, 0, 0, 10'd9);
    chk("sat_ovf", ovf0, 1);
    chk("sat_count9", count0, 8);
    chk("sat_top", top0, 8);
    chk("wrap_top9", top1, 9);
    for (int i = 8; i >= 1; i--) begin
      chk("sat_pop", top0, 10'(i));
      cyc(0, 1, 0, 0, 10'd0);
    end
    cyc(0, 1, 0, 0, 10'd0);
    chk("sat_unf", unf0, 1);
    chk("sat_cnt0", count0, 0);

    // wrap: push 1..10, pop x8
    cyc(0, 0, 1, 0, 10'd0);
    cyc(0, 0, 0, 1, 10'd0);
    for (int i = 1; i <= 10; i++) cyc(1, 0, 0, 0, 10'(i));
    chk("wrap_count", count1, 8);
    chk("wrap_ovf", ovf1, 1);
    for (int i = 10; i >= 3; i--) begin
      chk("wrap_pop", top1, 10'(i));
      cyc(0, 1, 0, 0, 10'd0);
    end
    chk("wrap_empty", empty1, 1);

    // push+pop replace, and on empty
    cyc(0, 0, 1, 0, 10'd0);
    cyc(0, 0, 0, 1, 10'd0);
    cyc(1, 0, 0, 0, 10'h020);
    cyc(1, 1, 0, 0, 10'h030);
    chk("rep_count", count0, 1);
    chk("rep_top", top0, 10'h030);
    chk("rep_unf", unf0, 0);
    cyc(0, 0, 1, 0, 10'd0);
    cyc(1, 1, 0, 0, 10'h040);
    chk("rep_e_count", count0, 1);
    chk("rep_e_top", top0, 10'h040);
    chk("rep_e_unf", unf0, 1);

    // flush beats push; err_clr; set beats err_clr
    cyc(0, 0, 1, 0, 10'd0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 10'(i + 16));
    cyc(1, 0, 1, 0, 10'h3FF);
    chk("fl_count", count0, 0);
    chk("fl_top", top0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 10'(i + 32));
    chk("ec_ovf_set", ovf0, 1);
    cyc(0, 0, 0, 1, 10'd0);
    chk("ec_ovf_clr", ovf0, 0);
    cyc(0, 0, 1, 0, 10'd0);
    cyc(0, 1, 0, 1, 10'd0);
    chk("ec_unf_win", unf0, 1);

    // async reset between edges
    cyc(0, 0, 0, 1, 10'd0);
    cyc(1, 0, 0, 0, 10'h111);
    cyc(1, 0, 0, 0, 10'h222);
    cyc(0, 1, 0, 0, 10'd0);
    cyc(0, 1, 0, 0, 10'd0);
    cyc(0, 1, 0, 0, 10'd0);
    cyc(1, 0, 0, 0, 10'h111);
    cyc(1, 0, 0, 0, 10'h222);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("ar_count", count0, 0);
    chk("ar_empty", empty0, 1);
    chk("ar_ovf", ovf0, 0);
    chk("ar_unf", unf0, 0);
    chk("ar_top", top0, 0);
    model_reset();
    #1 reset = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic pu, po, fl, ec;
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 42);
      fl = ($urandom_range(0, 31) == 0);
      ec = !fl && ($urandom_range(0, 15) == 0);
      cyc(pu, po, fl, ec, 10'($urandom_range(0, 1023)));
    end
    idle();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ret_stack.md
Name: ret_stack

Overview:
Parametrised hardware return-address stack for the CPU control path. CALL-type instructions push the return PC and RET pops it. It is fully synchronous and has configurable width and depth, full/empty/count status, sticky overflow and underflow error flags, a flush, simultaneous push+pop, and a selectable full-stack policy (saturate or wrap). The top of stack is read combinationally, so the PC-next mux can use it in the same cycle as RET.

Parameters:
WIDTH, 10, bit width of each stored entry (PC width).
PTR_W, 3, pointer width; DEPTH = 2**PTR_W entries (default 8).
WRAP, 0, full-stack policy: 0 = saturate (discard push), 1 = wrap (overwrite oldest entry).

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
push  in  1  push push_data at the next rising edge.
pop  in  1  remove the top entry at the next rising edge.
flush  in  1  synchronous empty-the-stack command.
err_clr  in  1  synchronous clear of the sticky error flags.
push_data  in  WIDTH  value to push.
top  out  WIDTH  current top entry; 0 when empty.
count  out  PTR_W+1  number of valid entries, 0..DEPTH.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
overflow  out  1  sticky flag: a push was made on a full stack without a pop.
underflow  out  1  sticky flag: a pop was made on an empty stack.

Behaviour:
- Reset (async, active-high): tp=0, count=0, overflow=0, underflow=0. Outputs then read top=0, empty=1, full=0. Memory array is not reset.
- Storage: DEPTH x WIDTH array; tp = next free index (PTR_W bits, modulo DEPTH). Top entry = mem[tp-1].
- top, empty and full are combinational from the current state; zero-latency read. Consumer samples top in the same cycle it asserts pop.
- Per-edge priority: flush > push/pop.
- flush=1: tp=0, count=0. push and pop are ignored that cycle. Error flags are unchanged. No new error is raised that cycle.
- push only, not full: mem[tp]<=push_data, tp+1, count+1.
- push only, full, WRAP=0: no write, state unchanged, overflow<=1.
- push only, full, WRAP=1: mem[tp]<=push_data, tp+1 (wraps), count stays DEPTH. The oldest entry is lost. overflow<=1.
- pop only, not empty: tp-1, count-1. The entry is not cleared.
- pop only, empty: state unchanged, underflow<=1.
- push+pop, not empty: replace the top entry: mem[tp-1]<=push_data. tp and count unchanged. No error, even when full.
- push+pop, empty: behaves as push only (count becomes 1), and underflow<=1.
- err_clr: overflow<=0, underflow<=0. If an error condition occurs in the same cycle, set wins.
- Pointer arithmetic is modulo DEPTH. count never exceeds DEPTH and never goes below 0.
- Reset asserted mid-operation: immediate clear regardless of clk. A push on the edge coincident with reset is lost.
- No combinational path from push/pop/push_data to any output.

Test Plan:
- Reset, then push 0x005, 0x00A, 0x0FF on consecutive cycles -> count=3, top=0x0FF, empty=0. Then pop x3 -> top reads 0x0FF, 0x00A, 0x005 in the pop cycles; after the last pop count=0, top=0, empty=1, underflow=0.
- WRAP=0: push 1..8 -> full=1, count=8. Push 9 -> overflow=1, count=8, top=8. Pop x8 -> 8..1. Pop again -> underflow=1, count=0.
- WRAP=1: push 1..10 -> count=8, overflow=1. Pop x8 -> 10,9,...,3 and the stack is empty.
- Push 0x020, then push+pop with 0x030 -> count=1, top=0x030. On an empty stack, push+pop with 0x040 -> count=1, top=0x040, underflow=1.
- Push 3 entries, then assert flush together with push=1 -> count=0, top=0. Assert err_clr while overflow=1 -> overflow=0. Assert err_clr together with a pop on empty -> underflow=1.
- Push 2 entries, pulse reset between clock edges -> count=0, empty=1, both flags 0 immediately, before the next edge.
